// File: rtl/uart_bus_pkg.sv
// Shared encodings and constants for the UART-to-bus responder slice.
// Optional write counter is enabled with the macro UART_RESP_WCNT_EN.
package uart_bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  // Counter byte positions, relative to the first address past the register bank.
  localparam int WCNT_LO_OFS = 0;
  localparam int WCNT_HI_OFS = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BRIDGE = 2'd1,
    ST_LOCAL  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_BRIDGE = 1'b0,
    OWN_LOC    = 1'b1
  } owner_e;

endpackage

// File: rtl/uart_bus_arb.sv
// Bus ownership arbiter: IDLE/BRIDGE/LOCAL FSM with round-robin tie break.
// Grants are registered and always equal the decode of the current state.
module uart_bus_arb
  import uart_bus_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic int_req,
  input  logic loc_req,
  output logic int_gnt,
  output logic loc_gnt
);

  state_e state_q;
  owner_e rr_last_q;
  logic   int_gnt_q;
  logic   loc_gnt_q;

  // Ownership FSM; grant flops are updated together with the state they decode.
  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rr_last_q <= OWN_LOC;
      int_gnt_q <= 1'b0;
      loc_gnt_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (int_req && (!loc_req || rr_last_q == OWN_LOC)) begin
            state_q   <= ST_BRIDGE;
            int_gnt_q <= 1'b1;
          end else if (loc_req) begin
            state_q   <= ST_LOCAL;
            loc_gnt_q <= 1'b1;
          end
        end
        ST_BRIDGE: begin
          if (!int_req) begin
            state_q   <= ST_IDLE;
            int_gnt_q <= 1'b0;
            rr_last_q <= OWN_BRIDGE;
          end
        end
        ST_LOCAL: begin
          if (!loc_req) begin
            state_q   <= ST_IDLE;
            loc_gnt_q <= 1'b0;
            rr_last_q <= OWN_LOC;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          int_gnt_q <= 1'b0;
          loc_gnt_q <= 1'b0;
        end
      endcase
    end
  end

  assign int_gnt = int_gnt_q;
  assign loc_gnt = loc_gnt_q;

endmodule

// File: rtl/uart_bus_responder.sv
// Register-file responder at the far end of the UART-to-bus bridge.
// Serves bridge reads/writes and local-master writes to NUM_REGS byte registers.
// Define UART_RESP_WCNT_EN to add a 16-bit accepted-write counter after the bank.
module uart_bus_responder
  import uart_bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0000,
  parameter int                NUM_REGS  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     int_address,
  input  logic [DATA_W-1:0]     int_wr_data,
  input  logic                  int_write,
  input  logic                  int_read,
  output logic [DATA_W-1:0]     int_rd_data,
  input  logic                  int_req,
  output logic                  int_gnt,
  input  logic                  loc_req,
  output logic                  loc_gnt,
  input  logic [ADDR_W-1:0]     loc_address,
  input  logic [DATA_W-1:0]     loc_wr_data,
  input  logic                  loc_write,
  output logic [8*NUM_REGS-1:0] ctrl_regs
);

  localparam int                IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W-1:0] NUM_REGS_A = ADDR_W'(NUM_REGS);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_val;

  // Offsets wrap in 16 bits, so addresses below BASE_ADDR land far out of range.
  logic [ADDR_W-1:0] int_ofs;
  logic [ADDR_W-1:0] loc_ofs;
  logic [ADDR_W-1:0] wr_ofs;
  logic [DATA_W-1:0] wr_data;
  logic              wr_stb;
  logic              wr_en;

  assign int_ofs = int_address - BASE_ADDR;
  assign loc_ofs = loc_address - BASE_ADDR;

  // Only one grant can be high, so the granted master selects the write port.
  assign wr_stb  = (int_write && int_gnt) || (loc_write && loc_gnt);
  assign wr_ofs  = int_gnt ? int_ofs : loc_ofs;
  assign wr_data = int_gnt ? int_wr_data : loc_wr_data;
  assign wr_en   = wr_stb && (wr_ofs < NUM_REGS_A);

  uart_bus_arb u_arb (
    .clock   (clock),
    .reset   (reset),
    .int_req (int_req),
    .loc_req (loc_req),
    .int_gnt (int_gnt),
    .loc_gnt (loc_gnt)
  );

`ifdef UART_RESP_WCNT_EN
  localparam logic [ADDR_W-1:0] CNT_LO_A = ADDR_W'(NUM_REGS + WCNT_LO_OFS);
  localparam logic [ADDR_W-1:0] CNT_HI_A = ADDR_W'(NUM_REGS + WCNT_HI_OFS);

  logic [15:0] wcnt_q;
  logic        cnt_clr;

  assign cnt_clr = wr_stb && (wr_ofs == CNT_LO_A || wr_ofs == CNT_HI_A);

  // Accepted-write counter; a clearing write is not itself counted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wcnt_q <= '0;
    end else if (cnt_clr) begin
      wcnt_q <= '0;
    end else if (wr_en) begin
      wcnt_q <= wcnt_q + 16'd1;
    end
  end
`endif

  // Bridge read mux: registers, optional counter bytes, otherwise zero.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    rd_val = '0;
    if (int_ofs < NUM_REGS_A) begin
      rd_val = regs_q[int_ofs[IDX_W-1:0]];
`ifdef UART_RESP_WCNT_EN
    end else if (int_ofs == CNT_LO_A) begin
      rd_val = wcnt_q[7:0];
    end else if (int_ofs == CNT_HI_A) begin
      rd_val = wcnt_q[15:8];
`endif
    end
  end

  // Register bank and read-data holding register; reads see the pre-write value.
  // NOTE: the bank is small control state with defined reset values, so it is reset like any flop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      if (wr_en) begin
        regs_q[wr_ofs[IDX_W-1:0]] <= wr_data;
      end
      if (int_read && int_gnt) begin
        rd_data_q <= rd_val;
      end
    end
  end

  assign int_rd_data = rd_data_q;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign ctrl_regs[8*k +: 8] = regs_q[k];
  end

endmodule

// File: tb/tb_uart_bus_responder.sv
// Directed self-checking bench for uart_bus_responder (BASE_ADDR=0, NUM_REGS=8).
// Counter checks are compiled in only when UART_RESP_WCNT_EN is defined.
`timescale 1ns/1ps
module tb_uart_bus_responder;

  logic        clock;
  logic        reset;
  logic [15:0] int_address;
  logic [7:0]  int_wr_data;
  logic        int_write;
  logic        int_read;
  logic [7:0]  int_rd_data;
  logic        int_req;
  logic        int_gnt;
  logic        loc_req;
  logic        loc_gnt;
  logic [15:0] loc_address;
  logic [7:0]  loc_wr_data;
  logic        loc_write;
  logic [63:0] ctrl_regs;

  int n_checks;
  int n_fails;

  uart_bus_responder #(.BASE_ADDR(16'h0000), .NUM_REGS(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .int_address (int_address),
    .int_wr_data (int_wr_data),
    .int_write   (int_write),
    .int_read    (int_read),
    .int_rd_data (int_rd_data),
    .int_req     (int_req),
    .int_gnt     (int_gnt),
    .loc_req     (loc_req),
    .loc_gnt     (loc_gnt),
    .loc_address (loc_address),
    .loc_wr_data (loc_wr_data),
    .loc_write   (loc_write),
    .ctrl_regs   (ctrl_regs)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_strobes();
    int_write = 1'b0;
    int_read  = 1'b0;
    loc_write = 1'b0;
  endtask

  task automatic do_reset();
    idle_strobes();
    int_req = 1'b0;
    loc_req = 1'b0;
    reset   = 1'b1;
    step();
    reset   = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_fails     = 0;
    int_address = '0;
    int_wr_data = '0;
    loc_address = '0;
    loc_wr_data = '0;
    int_req     = 1'b0;
    loc_req     = 1'b0;
    idle_strobes();
    reset = 1'b1;
    #12;
    check("rst_int_gnt", 64'(int_gnt), 64'd0);
    check("rst_loc_gnt", 64'(loc_gnt), 64'd0);
    check("rst_rd_data", 64'(int_rd_data), 64'h00);
    check("rst_ctrl", ctrl_regs, 64'd0);
    step();
    reset = 1'b0;

    // Bridge request granted one cycle later.
    int_req = 1'b1;
    step();
    check("gnt_after_1", 64'(int_gnt), 64'd1);
    check("loc_gnt_low", 64'(loc_gnt), 64'd0);

    // Write then read back register 3.
    int_address = 16'h0003; int_wr_data = 8'hA5; int_write = 1'b1;
    step();
    int_write = 1'b0; int_read = 1'b1;
    step();
    int_read = 1'b0;
    check("rd_reg3", 64'(int_rd_data), 64'hA5);
    check("ctrl_reg3", 64'(ctrl_regs[31:24]), 64'hA5);

    // Local write without grant is ignored; out-of-range read gives 00.
    loc_address = 16'h0001; loc_wr_data = 8'h3C; loc_write = 1'b1;
    step();
    loc_write = 1'b0;
    check("loc_no_gnt", 64'(ctrl_regs[15:8]), 64'h00);
    int_address = 16'h0020; int_read = 1'b1;
    step();
    int_read = 1'b0;
    check("rd_oor", 64'(int_rd_data), 64'h00);

    // Simultaneous read and write returns the old value.
    int_address = 16'h0002; int_wr_data = 8'h11; int_write = 1'b1;
    step();
    int_wr_data = 8'h22; int_read = 1'b1;
    step();
    idle_strobes();
    check("rw_old", 64'(int_rd_data), 64'h11);
    check("rw_new", 64'(ctrl_regs[23:16]), 64'h22);

    // Out-of-range write is dropped; bank holds 00_00_00_00_A5_22_00_00.
    int_address = 16'h0008; int_wr_data = 8'hEE; int_write = 1'b1;
    step();
    int_write = 1'b0;
    check("oor_write", ctrl_regs, 64'h00000000_A5220000);

`ifndef UART_RESP_WCNT_EN
    // Counter addresses are plain out-of-range reads without the feature.
    int_address = 16'h0003; int_read = 1'b1;
    step();
    int_address = 16'h0008;
    step();
    check("rd_0008", 64'(int_rd_data), 64'h00);
    int_address = 16'h0003;
    step();
    int_address = 16'h0009;
    step();
    int_read = 1'b0;
    check("rd_0009", 64'(int_rd_data), 64'h00);
`else
    // Counter: writes so far are 3 (A5, 11, 22); clear it first via 0x0009.
    int_address = 16'h0009; int_wr_data = 8'h00; int_write = 1'b1;
    step();
    int_address = 16'h0000;
    for (int i = 0; i < 65536; i++) begin
      int_wr_data = 8'(i);
      step();
    end
    int_write = 1'b0;
    int_address = 16'h0008; int_read = 1'b1;
    step();
    check("wcnt_wrap_lo", 64'(int_rd_data), 64'h00);
    int_address = 16'h0009;
    step();
    int_read = 1'b0;
    check("wcnt_wrap_hi", 64'(int_rd_data), 64'h00);
    int_address = 16'h0001; int_write = 1'b1;
    step(); step(); step();
    int_write = 1'b0;
    int_address = 16'h0008; int_read = 1'b1;
    step();
    check("wcnt3_lo", 64'(int_rd_data), 64'h03);
    int_address = 16'h0009;
    step();
    int_read = 1'b0;
    check("wcnt3_hi", 64'(int_rd_data), 64'h00);
    int_write = 1'b1;
    step();
    int_write = 1'b0;
    int_address = 16'h0008; int_read = 1'b1;
    step();
    int_read = 1'b0;
    check("wcnt_clr_lo", 64'(int_rd_data), 64'h00);
`endif

    // Tie after reset: bridge first, then local two cycles after release.
    do_reset();
    check("rst2_ctrl", ctrl_regs, 64'd0);
    int_req = 1'b1; loc_req = 1'b1;
    step();
    check("tie1_int", 64'(int_gnt), 64'd1);
    check("tie1_loc", 64'(loc_gnt), 64'd0);
    int_req = 1'b0;
    step();
    check("rel_idle_int", 64'(int_gnt), 64'd0);
    check("rel_idle_loc", 64'(loc_gnt), 64'd0);
    step();
    check("loc_granted", 64'(loc_gnt), 64'd1);

    // Local write lands; bridge strobes while ungranted do nothing.
    loc_address = 16'h0005; loc_wr_data = 8'h5A; loc_write = 1'b1;
    int_address = 16'h0005; int_read = 1'b1;
    step();
    idle_strobes();
    check("loc_write", 64'(ctrl_regs[47:40]), 64'h5A);
    check("rd_no_gnt", 64'(int_rd_data), 64'h00);
    int_address = 16'h0006; int_wr_data = 8'h77; int_write = 1'b1;
    step();
    int_write = 1'b0;
    check("wr_no_gnt", ctrl_regs, 64'h00005A00_00000000);

    // Local releases, then a fresh tie goes to the bridge again.
    loc_req = 1'b0;
    step();
    check("loc_release", 64'(loc_gnt), 64'd0);
    int_req = 1'b1; loc_req = 1'b1;
    step();
    check("tie2_int", 64'(int_gnt), 64'd1);
    check("tie2_loc", 64'(loc_gnt), 64'd0);

    // Asynchronous reset in the middle of a bridge write.
    loc_req = 1'b0;
    int_address = 16'h0004; int_wr_data = 8'h99; int_write = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("amid_int_gnt", 64'(int_gnt), 64'd0);
    check("amid_loc_gnt", 64'(loc_gnt), 64'd0);
    check("amid_rd", 64'(int_rd_data), 64'h00);
    check("amid_ctrl", ctrl_regs, 64'd0);
    step();
    int_write = 1'b0;
    reset = 1'b0;
    step();
    check("lost_write", ctrl_regs, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
